// File: rtl/spi_arbiter_if.sv
// One requester port of spi_arbiter: a TX byte handshake with end-of-transaction
// flag, plus a one-cycle RX byte pulse back to the requester.
interface spi_arbiter_if;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_last;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (output req_valid, req_data, req_last, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_data, req_last, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/spi_arbiter.sv
// Two-port SPI mode-0 master: round-robin arbitration with transaction lock,
// SCLK half-period divider and MSB-first byte shift engine.
module spi_arbiter #(
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div_i,
    spi_arbiter_if.slave      p0_if,
    spi_arbiter_if.slave      p1_if,
    output logic              cs0_n_o,
    output logic              cs1_n_o,
    output logic              sclk_o,
    output logic              sdo_o,
    input  logic              sdi_i,
    output logic              busy_o,
    output logic              owner_o
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_NEXT, HOLD} state_t;

    state_t           state_q;
    logic             owner_q;
    logic             rr_q;
    logic             last_q;
    logic             sclk_q;
    logic             sdo_q;
    logic             busy_q;
    logic             cs0_n_q;
    logic             cs1_n_q;
    logic [6:0]       tx_q;
    logic [7:0]       rx_q;
    logic [2:0]       bit_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W:0]   cnt_q;
    logic [1:0]       rsp_valid_q;
    logic [7:0]       rsp0_data_q;
    logic [7:0]       rsp1_data_q;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic             accept;
    logic             acc_port;
    logic [7:0]       acc_data;
    logic             acc_last;

    assign req_valid = {p1_if.req_valid, p0_if.req_valid};

    // Ready is combinational: a new owner in IDLE, or the locked owner between bytes.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            if (state_q == IDLE)
                grant = (req_valid == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : req_valid;
            else if (state_q == WAIT_NEXT)
                grant = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign accept   = |(grant & req_valid);
    assign acc_port = grant[1];
    assign acc_data = acc_port ? p1_if.req_data : p0_if.req_data;
    assign acc_last = acc_port ? p1_if.req_last : p0_if.req_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            busy_q      <= 1'b0;
            cs0_n_q     <= 1'b1;
            cs1_n_q     <= 1'b1;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE, WAIT_NEXT: begin
                    if (accept) begin
                        owner_q <= acc_port;
                        tx_q    <= acc_data[6:0];
                        sdo_q   <= acc_data[7];
                        last_q  <= acc_last;
                        div_q   <= cfg_div_i;
                        cs0_n_q <= acc_port;
                        cs1_n_q <= !acc_port;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    // Two half-periods of setup so the last falling edge lands at 17 HP.
                    if (cnt_q == {div_q, 1'b1}) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        rx_q    <= {rx_q[6:0], sdi_i};
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == {1'b0, div_q}) begin
                        cnt_q  <= '0;
                        sclk_q <= !sclk_q;
                        if (!sclk_q) begin
                            rx_q <= {rx_q[6:0], sdi_i};
                        end else if (bit_q == 3'd7) begin
                            rsp_valid_q[owner_q] <= 1'b1;
                            if (owner_q) rsp1_data_q <= rx_q;
                            else         rsp0_data_q <= rx_q;
                            state_q <= last_q ? HOLD : WAIT_NEXT;
                        end else begin
                            sdo_q <= tx_q[6];
                            tx_q  <= {tx_q[5:0], 1'b0};
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == {1'b0, div_q}) begin
                        cs0_n_q <= 1'b1;
                        cs1_n_q <= 1'b1;
                        busy_q  <= 1'b0;
                        rr_q    <= !owner_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p0_if.req_ready = grant[0];
    assign p1_if.req_ready = grant[1];
    assign p0_if.rsp_valid = rsp_valid_q[0];
    assign p1_if.rsp_valid = rsp_valid_q[1];
    assign p0_if.rsp_data  = rsp0_data_q;
    assign p1_if.rsp_data  = rsp1_data_q;
    assign cs0_n_o         = cs0_n_q;
    assign cs1_n_o         = cs1_n_q;
    assign sclk_o          = sclk_q;
    assign sdo_o           = sdo_q;
    assign busy_o          = busy_q;
    assign owner_o         = owner_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: per-cycle traces checked against hand-derived timing.
module tb_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_div;
    logic       cs0_n, cs1_n, sclk, sdo, sdi, busy, owner;
    logic       loop_en;
    logic [7:0] sdi_pat;
    logic [2:0] sdi_idx;
    int         rise_cnt = 0;
    logic       sclk_prev = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    spi_arbiter_if p0 ();
    spi_arbiter_if p1 ();

    spi_arbiter #(.DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div_i(cfg_div),
        .p0_if(p0), .p1_if(p1),
        .cs0_n_o(cs0_n), .cs1_n_o(cs1_n), .sclk_o(sclk), .sdo_o(sdo),
        .sdi_i(sdi), .busy_o(busy), .owner_o(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI slave: presents the next pattern bit after each observed SCLK rise.
    always @(negedge clk) begin
        if (cs0_n && cs1_n) rise_cnt <= 0;
        else if (sclk && !sclk_prev) rise_cnt <= rise_cnt + 1;
        sclk_prev <= sclk;
    end
    always_comb sdi_idx = 3'(7 - (rise_cnt % 8));
    assign sdi = loop_en ? sdo : sdi_pat[sdi_idx];

    typedef struct packed {
        logic cs0, cs1, sclk, sdo, busy, owner, r0v, r1v, rdy0, rdy1;
        logic [7:0] r0d, r1d;
    } obs_t;
    obs_t tr [0:199];

    function automatic obs_t sample();
        obs_t o;
        o.cs0 = cs0_n; o.cs1 = cs1_n; o.sclk = sclk; o.sdo = sdo;
        o.busy = busy; o.owner = owner; o.r0v = p0.rsp_valid; o.r1v = p1.rsp_valid;
        o.rdy0 = p0.req_ready; o.rdy1 = p1.req_ready;
        o.r0d = p0.rsp_data; o.r1d = p1.rsp_data;
        return o;
    endfunction

    function automatic int pulse_count(input int port, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if ((port == 0) ? tr[k].r0v : tr[k].r1v) c++;
        return c;
    endfunction

    function automatic int pulse_pos(input int port, input int n);
        for (int k = 1; k <= n; k++) if ((port == 0) ? tr[k].r0v : tr[k].r1v) return k;
        return -1;
    endfunction

    function automatic int cs_low_count(input int port, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (!((port == 0) ? tr[k].cs0 : tr[k].cs1)) c++;
        return c;
    endfunction

    function automatic logic [7:0] sdo_byte(input int n);
        logic [7:0] b = '0;
        for (int k = 1; k <= n; k++) if (tr[k].sclk && !tr[k-1].sclk) b = {b[6:0], tr[k].sdo};
        return b;
    endfunction

    task automatic wait_accept(input int port, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if ((port == 0) ? (p0.req_valid && p0.req_ready) : (p1.req_valid && p1.req_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture(input int n, input logic [1:0] drop);
        tr[0] = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tr[k] = sample();
            if (k == 1) begin
                if (drop[0]) p0.req_valid = 1'b0;
                if (drop[1]) p1.req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_div = 8'd0; loop_en = 1'b0; sdi_pat = 8'h00;
        p0.req_valid = 1'b1; p0.req_data = 8'hFF; p0.req_last = 1'b1;
        p1.req_valid = 1'b0; p1.req_data = 8'h00; p1.req_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs0_n, cs1_n, sclk, sdo, busy, owner, p0.req_ready, p1.req_ready, p0.rsp_valid, p1.rsp_valid} !== 10'b1100000000) begin
            errors++;
            $display("FAIL reset_lines: got %b expected %b", {cs0_n, cs1_n, sclk, sdo, busy, owner,
                     p0.req_ready, p1.req_ready, p0.rsp_valid, p1.rsp_valid}, 10'b1100000000);
        end
        checks++;
        if ({p0.rsp_data, p1.rsp_data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rsp_data: got %h expected 0000", {p0.rsp_data, p1.rsp_data});
        end
        p0.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_port0_div0();
        bit ok;
        cfg_div = 8'd0; loop_en = 1'b0; sdi_pat = 8'hA6;
        p0.req_data = 8'h6A; p0.req_last = 1'b1; p0.req_valid = 1'b1;
        wait_accept(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL div0_accept: got no grant expected grant"); end
        capture(22, 2'b01);
        checks++;
        if ({tr[1].cs0, tr[1].busy, tr[1].owner, tr[1].sdo} !== 4'b0100) begin
            errors++; $display("FAIL div0_start: got %b expected 0100", {tr[1].cs0, tr[1].busy, tr[1].owner, tr[1].sdo});
        end
        checks++;
        if ({tr[2].sclk, tr[3].sclk} !== 2'b01) begin
            errors++; $display("FAIL div0_first_rise: got %b expected 01", {tr[2].sclk, tr[3].sclk});
        end
        checks++;
        if (sdo_byte(22) !== 8'h6A) begin errors++; $display("FAIL div0_sdo: got %h expected 6a", sdo_byte(22)); end
        checks++;
        if (pulse_count(0, 22) != 1 || pulse_pos(0, 22) != 18) begin
            errors++; $display("FAIL div0_rsp_time: got %0d pulses at %0d expected 1 at 18", pulse_count(0, 22), pulse_pos(0, 22));
        end
        checks++;
        if (tr[18].r0d !== 8'hA6) begin errors++; $display("FAIL div0_rsp_data: got %h expected a6", tr[18].r0d); end
        checks++;
        if ({tr[18].cs0, tr[19].cs0} !== 2'b01) begin
            errors++; $display("FAIL div0_cs_release: got %b expected 01", {tr[18].cs0, tr[19].cs0});
        end
        checks++;
        if (cs_low_count(1, 22) != 0 || pulse_count(1, 22) != 0) begin
            errors++; $display("FAIL div0_port1_quiet: got %0d cs1 low, %0d rsp1 expected 0, 0", cs_low_count(1, 22), pulse_count(1, 22));
        end
    endtask

    task automatic test_port1_div3();
        bit ok;
        cfg_div = 8'd3; loop_en = 1'b1;
        p1.req_data = 8'h81; p1.req_last = 1'b1; p1.req_valid = 1'b1;
        wait_accept(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL div3_accept: got no grant expected grant"); end
        capture(75, 2'b10);
        checks++;
        if ({tr[8].sclk, tr[9].sclk, tr[12].sclk, tr[13].sclk, tr[16].sclk, tr[17].sclk} !== 6'b011001) begin
            errors++; $display("FAIL div3_sclk_period: got %b expected 011001",
                {tr[8].sclk, tr[9].sclk, tr[12].sclk, tr[13].sclk, tr[16].sclk, tr[17].sclk});
        end
        checks++;
        if (pulse_count(1, 75) != 1 || pulse_pos(1, 75) != 69) begin
            errors++; $display("FAIL div3_rsp_time: got %0d pulses at %0d expected 1 at 69", pulse_count(1, 75), pulse_pos(1, 75));
        end
        checks++;
        if (tr[69].r1d !== 8'h81) begin errors++; $display("FAIL div3_rsp_data: got %h expected 81", tr[69].r1d); end
        checks++;
        if ({tr[1].cs1, tr[72].cs1, tr[73].cs1} !== 3'b001) begin
            errors++; $display("FAIL div3_cs_window: got %b expected 001", {tr[1].cs1, tr[72].cs1, tr[73].cs1});
        end
        checks++;
        if (cs_low_count(0, 75) != 0 || pulse_count(0, 75) != 0) begin
            errors++; $display("FAIL div3_port0_quiet: got %0d cs0 low, %0d rsp0 expected 0, 0", cs_low_count(0, 75), pulse_count(0, 75));
        end
    endtask

    task automatic test_collision();
        bit ok;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; cfg_div = 8'd0; loop_en = 1'b1;
        p0.req_data = 8'h12; p0.req_last = 1'b1; p0.req_valid = 1'b1;
        p1.req_data = 8'h34; p1.req_last = 1'b1; p1.req_valid = 1'b1;
        #1;
        checks++;
        if ({p0.req_ready, p1.req_ready} !== 2'b10) begin
            errors++; $display("FAIL collide1_grant: got %b expected 10", {p0.req_ready, p1.req_ready});
        end
        wait_accept(0, ok);
        capture(19, 2'b11);
        checks++;
        if (cs_low_count(1, 19) != 0 || tr[1].cs0 !== 1'b0 || tr[19].cs0 !== 1'b1) begin
            errors++; $display("FAIL collide1_cs: got cs1 low %0d, cs0 %b%b expected 0, 01", cs_low_count(1, 19), tr[1].cs0, tr[19].cs0);
        end
        p0.req_data = 8'h56; p0.req_valid = 1'b1;
        p1.req_valid = 1'b1;
        #1;
        checks++;
        if ({p0.req_ready, p1.req_ready} !== 2'b01) begin
            errors++; $display("FAIL collide2_grant: got %b expected 01", {p0.req_ready, p1.req_ready});
        end
        wait_accept(1, ok);
        capture(3, 2'b11);
        checks++;
        if ({tr[1].cs0, tr[1].cs1, tr[1].owner, tr[1].busy} !== 4'b1011) begin
            errors++; $display("FAIL collide2_owner: got %b expected 1011", {tr[1].cs0, tr[1].cs1, tr[1].owner, tr[1].busy});
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL collide2_idle: got busy expected idle"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad_cs, bad_rdy, bad_rsp;
        cfg_div = 8'd0; loop_en = 1'b1;
        p0.req_data = 8'h11; p0.req_last = 1'b0; p0.req_valid = 1'b1;
        p1.req_data = 8'h77; p1.req_last = 1'b1; p1.req_valid = 1'b1;
        wait_accept(0, ok);
        checks++;
        if (!ok || p1.req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_first_grant: got ok=%0d rdy1=%b expected ok=1 rdy1=0", ok, p1.req_ready);
        end
        tr[0] = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            tr[k] = sample();
            if (k == 1)  p0.req_data = 8'h22;
            if (k == 19) begin p0.req_data = 8'h33; p0.req_last = 1'b1; end
            if (k == 37) p0.req_valid = 1'b0;
            if (k == 56) p1.req_valid = 1'b0;
        end
        bad_cs = 0; bad_rdy = 0; bad_rsp = 0;
        for (int k = 1; k <= 54; k++) begin
            if (tr[k].cs0 !== 1'b0) bad_cs++;
            if (tr[k].rdy1 !== 1'b0) bad_rdy++;
        end
        for (int k = 1; k <= 60; k++) if (tr[k].r0v !== (k == 18 || k == 36 || k == 54)) bad_rsp++;
        checks++;
        if (bad_cs != 0 || tr[55].cs0 !== 1'b1) begin
            errors++; $display("FAIL b2b_cs0_hold: got %0d gaps, release %b expected 0 gaps, release 1", bad_cs, tr[55].cs0);
        end
        checks++;
        if (bad_rdy != 0 || tr[55].rdy1 !== 1'b1) begin
            errors++; $display("FAIL b2b_port1_blocked: got %0d early readys, rdy1@55=%b expected 0, 1", bad_rdy, tr[55].rdy1);
        end
        checks++;
        if ({tr[18].rdy0, tr[36].rdy0} !== 2'b11) begin
            errors++; $display("FAIL b2b_owner_ready: got %b expected 11", {tr[18].rdy0, tr[36].rdy0});
        end
        checks++;
        if (bad_rsp != 0) begin errors++; $display("FAIL b2b_rsp_times: got %0d misplaced pulses expected 0", bad_rsp); end
        checks++;
        if ({tr[18].r0d, tr[36].r0d, tr[54].r0d} !== 24'h112233) begin
            errors++; $display("FAIL b2b_rsp_data: got %h expected 112233", {tr[18].r0d, tr[36].r0d, tr[54].r0d});
        end
        checks++;
        if ({tr[56].cs1, tr[56].cs0, tr[56].owner} !== 3'b011) begin
            errors++; $display("FAIL b2b_port1_served: got %b expected 011", {tr[56].cs1, tr[56].cs0, tr[56].owner});
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_idle: got busy expected idle"); end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        cfg_div = 8'd1; loop_en = 1'b1;
        p0.req_data = 8'h5C; p0.req_last = 1'b0; p0.req_valid = 1'b1;
        wait_accept(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_accept: got no grant expected grant"); end
        tr[0] = '0;
        for (int k = 1; k <= 125; k++) begin
            @(negedge clk);
            tr[k] = sample();
            if (k == 1)  p0.req_valid = 1'b0;
            if (k == 5)  cfg_div = 8'd5;
            if (k == 80) cfg_div = 8'd1;
            if (k == 85) begin p0.req_data = 8'hC3; p0.req_last = 1'b1; p0.req_valid = 1'b1; end
            if (k == 86) p0.req_valid = 1'b0;
        end
        checks++;
        if ({tr[34].r0v, tr[35].r0v} !== 2'b01 || tr[35].r0d !== 8'h5C) begin
            errors++; $display("FAIL stall_first_rsp: got %b/%h expected 01/5c", {tr[34].r0v, tr[35].r0v}, tr[35].r0d);
        end
        bad = 0;
        for (int k = 35; k <= 85; k++) if ({tr[k].cs0, tr[k].sclk, tr[k].rdy0} !== 3'b001) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_wait_lines: got %0d bad cycles expected 0", bad); end
        checks++;
        if ({tr[86].cs0, tr[86].sdo, tr[89].sclk, tr[90].sclk} !== 4'b0101) begin
            errors++; $display("FAIL stall_resume: got %b expected 0101", {tr[86].cs0, tr[86].sdo, tr[89].sclk, tr[90].sclk});
        end
        checks++;
        if ({tr[119].r0v, tr[120].r0v} !== 2'b01 || tr[120].r0d !== 8'hC3) begin
            errors++; $display("FAIL stall_second_rsp: got %b/%h expected 01/c3", {tr[119].r0v, tr[120].r0v}, tr[120].r0d);
        end
        checks++;
        if ({tr[121].cs0, tr[122].cs0} !== 2'b01) begin
            errors++; $display("FAIL stall_hold: got %b expected 01", {tr[121].cs0, tr[122].cs0});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        cfg_div = 8'd0; loop_en = 1'b1;
        p1.req_data = 8'hF0; p1.req_last = 1'b1; p1.req_valid = 1'b1;
        wait_accept(1, ok);
        capture(7, 2'b10);
        checks++;
        if ({tr[7].cs1, tr[7].sclk, tr[7].sdo} !== 3'b011) begin
            errors++; $display("FAIL midrst_pre: got %b expected 011", {tr[7].cs1, tr[7].sclk, tr[7].sdo});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs0_n, cs1_n, sclk, sdo, busy} !== 5'b11000) begin
            errors++; $display("FAIL midrst_async: got %b expected 11000", {cs0_n, cs1_n, sclk, sdo, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        capture(20, 2'b00);
        checks++;
        if (pulse_count(1, 20) != 0 || cs_low_count(1, 20) != 0) begin
            errors++; $display("FAIL midrst_no_rsp: got %0d pulses, %0d cs low expected 0, 0", pulse_count(1, 20), cs_low_count(1, 20));
        end
        p0.req_data = 8'h3C; p0.req_last = 1'b1; p0.req_valid = 1'b1;
        wait_accept(0, ok);
        capture(20, 2'b01);
        checks++;
        if (!ok || pulse_pos(0, 20) != 18 || tr[18].r0d !== 8'h3C) begin
            errors++; $display("FAIL midrst_recover: got rsp at %0d data %h expected 18, 3c", pulse_pos(0, 20), tr[18].r0d);
        end
    endtask

    initial begin
        test_reset();
        test_port0_div0();
        test_port1_div3();
        test_collision();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
